// File: rtl/syst_ws_ctrl.sv
// Sequencer for the 3-in/2-out weight-stationary systolic array: skews input vectors
// into the array, tags them through its latency, realigns y1/y2 and buffers results.
module syst_ws_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 19,
  parameter int Y1_LAT     = 3,
  parameter int Y2_LAT     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int INIT_CYC   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_x1_i,
  input  logic [DATA_W-1:0] s_x2_i,
  input  logic [DATA_W-1:0] s_x3_i,
  output logic              arr_rst_o,
  output logic [DATA_W-1:0] arr_x1_o,
  output logic [DATA_W-1:0] arr_x2_o,
  output logic [DATA_W-1:0] arr_x3_o,
  input  logic [ACC_W-1:0]  arr_y1_i,
  input  logic [ACC_W-1:0]  arr_y2_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [ACC_W-1:0]  m_y1_o,
  output logic [ACC_W-1:0]  m_y2_o,
  output logic              busy_o
);

  localparam int DLY_LAT = Y2_LAT - Y1_LAT;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int IW      = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  if (Y2_LAT < Y1_LAT) begin : g_bad_lat_order
    $error("syst_ws_ctrl: Y2_LAT must be >= Y1_LAT");
  end
  if (Y1_LAT < 1) begin : g_bad_lat_min
    $error("syst_ws_ctrl: Y1_LAT must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("syst_ws_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (INIT_CYC < 1) begin : g_bad_init
    $error("syst_ws_ctrl: INIT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [ACC_W-1:0] y1;
    logic [ACC_W-1:0] y2;
  } res_t;

  state_e           state_q, state_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;

  logic [DATA_W-1:0] x1_q;
  logic [DATA_W-1:0] x2_sk_q [2];
  logic [DATA_W-1:0] x3_sk_q [3];

  logic [Y2_LAT:0]  tag_q;
  logic [CW-1:0]    inflight_q;
  logic [ACC_W-1:0] y1_aligned;

  res_t             fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, push, pop;
  logic [CW:0]      credits_used;
  res_t             head;

  // Each accepted vector holds a credit from acceptance until its result is popped,
  // so one vector per cycle is only sustained when FIFO_DEPTH >= Y2_LAT + 3.
  assign credits_used = {1'b0, inflight_q} + {1'b0, cnt_q};
  assign s_ready_o    = (state_q != ST_INIT) && !flush_i
                        && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign accept       = s_valid_i && s_ready_o;
  assign push         = tag_q[Y2_LAT];
  assign pop          = m_valid_o && m_ready_i;

  assign arr_rst_o = !rst_ni || (state_q == ST_INIT);
  assign arr_x1_o  = x1_q;
  assign arr_x2_o  = x2_sk_q[1];
  assign arr_x3_o  = x3_sk_q[2];

  assign head      = fifo_mem_q[rd_ptr_q];
  assign m_valid_o = (cnt_q != '0);
  assign m_y1_o    = m_valid_o ? head.y1 : '0;
  assign m_y2_o    = m_valid_o ? head.y2 : '0;
  assign busy_o    = (state_q != ST_IDLE) || (inflight_q != '0) || (cnt_q != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == IW'(INIT_CYC - 1)) begin
          state_d    = ST_IDLE;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!accept) state_d = (inflight_q != '0) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (accept)                  state_d = ST_RUN;
        else if (inflight_q == '0)   state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
    if (flush_i) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
    end
  end

  // Skew lanes: unscheduled slots carry zero so the array's partial sums stay clean.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x1_q    <= '0;
      x2_sk_q <= '{default: '0};
      x3_sk_q <= '{default: '0};
    end else if (flush_i) begin
      x1_q    <= '0;
      x2_sk_q <= '{default: '0};
      x3_sk_q <= '{default: '0};
    end else begin
      x1_q       <= accept ? s_x1_i : '0;
      x2_sk_q[0] <= accept ? s_x2_i : '0;
      x2_sk_q[1] <= x2_sk_q[0];
      x3_sk_q[0] <= accept ? s_x3_i : '0;
      x3_sk_q[1] <= x3_sk_q[0];
      x3_sk_q[2] <= x3_sk_q[1];
    end
  end

  // tag_q[k] marks the vector whose x1 was on arr_x1_o k cycles ago.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q      <= '0;
      inflight_q <= '0;
    end else if (flush_i) begin
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      tag_q      <= {tag_q[Y2_LAT-1:0], accept};
      inflight_q <= inflight_q + CW'(accept) - CW'(push);
    end
  end

  if (DLY_LAT == 0) begin : g_y1_direct
    assign y1_aligned = arr_y1_i;
  end else begin : g_y1_delay
    logic [ACC_W-1:0] y1_dl_q [DLY_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        y1_dl_q <= '{default: '0};
      end else if (flush_i) begin
        y1_dl_q <= '{default: '0};
      end else begin
        y1_dl_q[0] <= tag_q[Y1_LAT] ? arr_y1_i : '0;
        for (int i = 1; i < DLY_LAT; i++) y1_dl_q[i] <= y1_dl_q[i-1];
      end
    end

    assign y1_aligned = y1_dl_q[DLY_LAT-1];
  end

  // NOTE: the result storage has no reset; occupancy is tracked by the pointers and
  // count, and the outputs are gated to zero while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= '{y1: y1_aligned, y2: arr_y2_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_syst_ws_ctrl.sv
// Scoreboard bench for syst_ws_ctrl with a behavioural stub of the systolic array.
module tb_syst_ws_ctrl;
  localparam int DATA_W     = 8;
  localparam int ACC_W      = 19;
  localparam int Y1_LAT     = 3;
  localparam int Y2_LAT     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int INIT_CYC   = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              s_valid_i = 1'b0;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_x1_i = '0, s_x2_i = '0, s_x3_i = '0;
  logic              arr_rst_o;
  logic [DATA_W-1:0] arr_x1_o, arr_x2_o, arr_x3_o;
  logic [ACC_W-1:0]  arr_y1_i, arr_y2_i;
  logic              m_valid_o;
  logic              m_ready_i = 1'b0;
  logic [ACC_W-1:0]  m_y1_o, m_y2_o;
  logic              busy_o;

  typedef struct {
    int y1;
    int y2;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_out = 0;

  always #5 clk_i = ~clk_i;

  syst_ws_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .Y1_LAT(Y1_LAT), .Y2_LAT(Y2_LAT),
    .FIFO_DEPTH(FIFO_DEPTH), .INIT_CYC(INIT_CYC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_x1_i(s_x1_i), .s_x2_i(s_x2_i), .s_x3_i(s_x3_i),
    .arr_rst_o(arr_rst_o),
    .arr_x1_o(arr_x1_o), .arr_x2_o(arr_x2_o), .arr_x3_o(arr_x3_o),
    .arr_y1_i(arr_y1_i), .arr_y2_i(arr_y2_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_y1_o(m_y1_o), .m_y2_o(m_y2_o), .busy_o(busy_o)
  );

  // Array stub: h*[k] holds the lane value from k+1 cycles ago.
  // y1(c) = x1(c-3) + x2(c-2) + x3(c-1); y2(c) = x1(c-4) + 2*x2(c-3) + 3*x3(c-2).
  logic [DATA_W-1:0] h1 [4];
  logic [DATA_W-1:0] h2 [4];
  logic [DATA_W-1:0] h3 [4];

  always @(posedge clk_i) begin
    if (arr_rst_o) begin
      for (int i = 0; i < 4; i++) begin
        h1[i] <= '0; h2[i] <= '0; h3[i] <= '0;
      end
    end else begin
      h1[0] <= arr_x1_o; h2[0] <= arr_x2_o; h3[0] <= arr_x3_o;
      for (int i = 1; i < 4; i++) begin
        h1[i] <= h1[i-1]; h2[i] <= h2[i-1]; h3[i] <= h3[i-1];
      end
    end
  end

  always_comb begin
    arr_y1_i = ACC_W'(h1[2]) + ACC_W'(h2[1]) + ACC_W'(h3[0]);
    arr_y2_i = ACC_W'(h1[3]) + (ACC_W'(h2[2]) << 1) + ACC_W'(h3[1]) * ACC_W'(3);
  end

  function automatic exp_t model(input logic [DATA_W-1:0] a, b, c);
    exp_t e;
    e.y1 = int'(a) + int'(b) + int'(c);
    e.y2 = int'(a) + 2 * int'(b) + 3 * int'(c);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: head of the result stream must match the scoreboard front every valid cycle.
  always @(negedge clk_i) begin
    #3;
    if (rst_ni && !flush_i && m_valid_o) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL spurious_output: got y1=%0d y2=%0d, expected no output", m_y1_o, m_y2_o);
      end else begin
        check("out_y1", 64'(m_y1_o), 64'(exp_q[0].y1));
        check("out_y2", 64'(m_y2_o), 64'(exp_q[0].y2));
        if (m_ready_i) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] a, b, c,
                       input logic mr, input logic fl, output logic acc);
    @(negedge clk_i);
    s_valid_i = v;
    s_x1_i    = a;
    s_x2_i    = b;
    s_x3_i    = c;
    m_ready_i = mr;
    flush_i   = fl;
    #2;
    acc = v && s_ready_o;
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(model(a, b, c));
  endtask

  task automatic idle(input int n, input logic mr);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, mr, 1'b0, acc);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int   n;
    logic acc;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < max_cyc) begin
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_not_busy"}, 64'(busy_o), 64'd0);
  endtask

  task automatic apply_reset(input string name, input int low_cycles);
    int n;
    @(negedge clk_i);
    rst_ni    = 1'b0;
    s_valid_i = 1'b0;
    flush_i   = 1'b0;
    exp_q.delete();
    #2;
    check({name, "_arr_rst"}, 64'(arr_rst_o), 64'd1);
    check({name, "_s_ready"}, 64'(s_ready_o), 64'd0);
    check({name, "_m_valid"}, 64'(m_valid_o), 64'd0);
    check({name, "_m_y1"}, 64'(m_y1_o), 64'd0);
    check({name, "_m_y2"}, 64'(m_y2_o), 64'd0);
    check({name, "_busy"}, 64'(busy_o), 64'd1);
    check({name, "_arr_x"}, 64'({arr_x1_o, arr_x2_o, arr_x3_o}), 64'd0);
    for (int i = 1; i < low_cycles; i++) @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #2;
    n = 0;
    while (arr_rst_o && n < 10) begin
      check({name, "_init_not_ready"}, 64'(s_ready_o), 64'd0);
      n++;
      @(negedge clk_i);
      #2;
    end
    check({name, "_init_cycles"}, 64'(n), 64'(INIT_CYC));
    check({name, "_ready_after_init"}, 64'(s_ready_o), 64'd1);
    check({name, "_no_valid_after_init"}, 64'(m_valid_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic              acc;
    logic [DATA_W-1:0] a, b, c;
    int                sent, cyc, out0, cnt;
    logic              pend, v;

    // 1: power-on reset and init window
    apply_reset("t1", 3);

    // 2: single vector (1,2,3), skew and latency
    drive(1'b1, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0, acc);
    check("t2_accept", 64'(acc), 64'd1);
    idle(1, 1'b1);
    check("t2_lane_t1", 64'({arr_x1_o, arr_x2_o, arr_x3_o}), 64'({8'd1, 8'd0, 8'd0}));
    idle(1, 1'b1);
    check("t2_lane_t2", 64'({arr_x1_o, arr_x2_o, arr_x3_o}), 64'({8'd0, 8'd2, 8'd0}));
    idle(1, 1'b1);
    check("t2_lane_t3", 64'({arr_x1_o, arr_x2_o, arr_x3_o}), 64'({8'd0, 8'd0, 8'd3}));
    idle(2, 1'b1);
    check("t2_valid_t5", 64'(m_valid_o), 64'd0);
    idle(1, 1'b1);
    check("t2_valid_t6", 64'(m_valid_o), 64'd1);
    check("t2_y1", 64'(m_y1_o), 64'd6);
    check("t2_y2", 64'(m_y2_o), 64'd14);
    wait_drain("t2", 20);

    // 3: 100 random vectors, sink always ready
    out0 = n_out;
    sent = 0;
    cyc  = 0;
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); c = 8'($urandom_range(0, 255));
    while (sent < 100 && cyc < 1000) begin
      drive(1'b1, a, b, c, 1'b1, 1'b0, acc);
      cyc++;
      if (acc) begin
        sent++;
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); c = 8'($urandom_range(0, 255));
      end
    end
    check("t3_sent", 64'(sent), 64'd100);
    check("t3_cycle_bound", 64'(cyc <= 100 * (Y2_LAT + 3) / FIFO_DEPTH + 10), 64'd1);
    wait_drain("t3", 40);
    check("t3_results", 64'(n_out - out0), 64'd100);

    // 3b: random valid and random ready, valid held until accepted
    out0 = n_out;
    sent = 0;
    cyc  = 0;
    pend = 1'b0;
    v    = 1'b0;
    while (sent < 60 && cyc < 2000) begin
      if (!pend) begin
        v = ($urandom_range(0, 2) != 0);
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); c = 8'($urandom_range(0, 255));
      end
      drive(v, a, b, c, ($urandom_range(0, 3) != 0), 1'b0, acc);
      cyc++;
      if (acc) sent++;
      pend = v && !acc;
    end
    check("t3b_sent", 64'(sent), 64'd60);
    wait_drain("t3b", 60);
    check("t3b_results", 64'(n_out - out0), 64'd60);

    // 4: sink stalled, credits cap acceptance at FIFO_DEPTH
    out0 = n_out;
    cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'b0, 1'b0, acc);
      if (acc) cnt++;
    end
    check("t4_accepts", 64'(cnt), 64'(FIFO_DEPTH));
    check("t4_ready_low", 64'(s_ready_o), 64'd0);
    check("t4_valid_held", 64'(m_valid_o), 64'd1);
    wait_drain("t4", 30);
    check("t4_results", 64'(n_out - out0), 64'(FIFO_DEPTH));

    // 5: flush with results buffered and vectors in flight
    out0 = n_out;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'(10 + i), 8'(20 + i), 8'(30 + i), 1'b0, 1'b0, acc);
      check("t5_accept_buf", 64'(acc), 64'd1);
    end
    idle(6, 1'b0);
    check("t5_buffered_valid", 64'(m_valid_o), 64'd1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'(40 + i), 8'(50 + i), 8'(60 + i), 1'b0, 1'b0, acc);
      check("t5_accept_flight", 64'(acc), 64'd1);
    end
    idle(1, 1'b0);
    drive(1'b1, 8'd9, 8'd9, 8'd9, 1'b0, 1'b1, acc);
    check("t5_flush_blocks_ready", 64'(s_ready_o), 64'd0);
    idle(1, 1'b0);
    check("t5_valid_cleared", 64'(m_valid_o), 64'd0);
    check("t5_arr_rst_1", 64'(arr_rst_o), 64'd1);
    check("t5_lanes_cleared", 64'({arr_x1_o, arr_x2_o, arr_x3_o}), 64'd0);
    check("t5_ready_init_1", 64'(s_ready_o), 64'd0);
    idle(1, 1'b0);
    check("t5_arr_rst_2", 64'(arr_rst_o), 64'd1);
    check("t5_ready_init_2", 64'(s_ready_o), 64'd0);
    idle(1, 1'b1);
    check("t5_arr_rst_done", 64'(arr_rst_o), 64'd0);
    check("t5_ready_back", 64'(s_ready_o), 64'd1);
    idle(15, 1'b1);
    check("t5_no_results", 64'(n_out - out0), 64'd0);
    check("t5_not_busy", 64'(busy_o), 64'd0);

    // 6: full-scale inputs, then reset while vectors are in flight
    drive(1'b1, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0, acc);
    check("t6_accept", 64'(acc), 64'd1);
    cnt = 0;
    while (!m_valid_o && cnt < 12) begin
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, acc);
      cnt++;
    end
    check("t6_max_y1", 64'(m_y1_o), 64'd765);
    check("t6_max_y2", 64'(m_y2_o), 64'd1530);
    wait_drain("t6", 20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'b1, 1'b0, acc);
    end
    out0 = n_out;
    apply_reset("t6_rst", 2);
    idle(15, 1'b1);
    check("t6_no_results", 64'(n_out - out0), 64'd0);
    check("t6_not_busy", 64'(busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
